// File: rtl/countdown_timer.sv
// Down-counting hh:mm:ss timer with load/start/pause/clear control and expiry alarm.
// Decrements on the tick enable with a sec->min->hr borrow chain; all outputs registered.
module countdown_timer #(
   parameter int SEC_MAX = 60,
   parameter int MIN_MAX = 60,
   parameter int HR_MAX  = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [7:0] load_hr,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [7:0] hr,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic [1:0] state,
   output logic       expired,
   output logic       expired_pulse
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      PAUSED  = 2'b10,
      EXPIRED = 2'b11
   } state_t;

   localparam logic [7:0] SEC_TOP = 8'(SEC_MAX - 1);
   localparam logic [7:0] MIN_TOP = 8'(MIN_MAX - 1);
   localparam logic [7:0] HR_TOP  = 8'(HR_MAX - 1);

   state_t     cur;
   logic [7:0] hr_in;
   logic [7:0] min_in;
   logic [7:0] sec_in;
   logic       count_zero;
   logic       last_second;

   // Out-of-range load values saturate to the top of each field.
   assign hr_in  = (load_hr  > HR_TOP)  ? HR_TOP  : load_hr;
   assign min_in = (load_min > MIN_TOP) ? MIN_TOP : load_min;
   assign sec_in = (load_sec > SEC_TOP) ? SEC_TOP : load_sec;

   assign count_zero  = (hr == 8'd0) && (min == 8'd0) && (sec == 8'd0);
   assign last_second = (hr == 8'd0) && (min == 8'd0) && (sec == 8'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur           <= IDLE;
         hr            <= 8'd0;
         min           <= 8'd0;
         sec           <= 8'd0;
         expired       <= 1'b0;
         expired_pulse <= 1'b0;
      end else begin
         expired_pulse <= 1'b0;
         if (load && cur != RUN) begin
            hr      <= hr_in;
            min     <= min_in;
            sec     <= sec_in;
            cur     <= IDLE;
            expired <= 1'b0;
         end else begin
            unique case (cur)
               IDLE, PAUSED: begin
                  if (start && !count_zero)
                     cur <= RUN;
               end
               RUN: begin
                  // Pause outranks tick, so a coincident tick is dropped.
                  if (pause) begin
                     cur <= PAUSED;
                  end else if (tick) begin
                     if (sec != 8'd0) begin
                        sec <= sec - 8'd1;
                     end else begin
                        sec <= SEC_TOP;
                        if (min != 8'd0) begin
                           min <= min - 8'd1;
                        end else begin
                           min <= MIN_TOP;
                           hr  <= hr - 8'd1;
                        end
                     end
                     if (last_second) begin
                        cur           <= EXPIRED;
                        expired       <= 1'b1;
                        expired_pulse <= 1'b1;
                     end
                  end
               end
               EXPIRED: begin
                  if (clear) begin
                     cur     <= IDLE;
                     expired <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random control traffic,
// checked every cycle against a total-seconds reference model.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       load;
   logic [7:0] load_hr;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic       start;
   logic       pause;
   logic       clear;
   logic [7:0] hr;
   logic [7:0] min;
   logic [7:0] sec;
   logic [1:0] state;
   logic       expired;
   logic       expired_pulse;

   int checks = 0;
   int errors = 0;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
   int m_total;
   int m_state;
   int m_exp;
   int m_pulse;

   countdown_timer dut (
      .clk(clk), .reset(reset), .tick(tick), .load(load),
      .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
      .start(start), .pause(pause), .clear(clear),
      .hr(hr), .min(min), .sec(sec), .state(state),
      .expired(expired), .expired_pulse(expired_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clampv(input int v, input int lim);
      return (v > lim - 1) ? lim - 1 : v;
   endfunction

   task automatic model_reset();
      m_total = 0; m_state = M_IDLE; m_exp = 0; m_pulse = 0;
   endtask

   // One clock edge of the reference, working on a single seconds total.
   task automatic model_step();
      m_pulse = 0;
      if (load && m_state != M_RUN) begin
         m_total = clampv(load_hr, 100) * 3600 + clampv(load_min, 60) * 60 + clampv(load_sec, 60);
         m_state = M_IDLE;
         m_exp   = 0;
      end else if (m_state == M_RUN) begin
         if (pause) m_state = M_PAUSED;
         else if (tick) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
               m_state = M_EXPIRED; m_exp = 1; m_pulse = 1;
            end
         end
      end else if (m_state == M_EXPIRED) begin
         if (clear) begin m_state = M_IDLE; m_exp = 0; end
      end else if (start && m_total != 0) begin
         m_state = M_RUN;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".hr"},    hr,            m_total / 3600);
      check({tag, ".min"},   min,           (m_total / 60) % 60);
      check({tag, ".sec"},   sec,           m_total % 60);
      check({tag, ".state"}, state,         m_state);
      check({tag, ".exp"},   expired,       m_exp);
      check({tag, ".pulse"}, expired_pulse, m_pulse);
   endtask

   task automatic idle_in();
      tick = 0; load = 0; start = 0; pause = 0; clear = 0;
      load_hr = 0; load_min = 0; load_sec = 0;
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
      idle_in();
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load = 1; load_hr = 8'(h); load_min = 8'(m); load_sec = 8'(s);
      cycle("load");
   endtask

   // Reset asserted away from any clock edge must act immediately.
   task automatic async_reset(input string tag);
      #2 reset = 1;
      #1;
      check({tag, ".hr"},    hr,      0);
      check({tag, ".min"},   min,     0);
      check({tag, ".sec"},   sec,     0);
      check({tag, ".state"}, state,   0);
      check({tag, ".exp"},   expired, 0);
      check({tag, ".pulse"}, expired_pulse, 0);
      model_reset();
      #2 reset = 0;
   endtask

   initial begin
      idle_in();
      reset = 1;
      model_reset();
      #12;
      check_all("reset");
      reset = 0;

      // 0:01:05 counts through the minute borrow.
      do_load(0, 1, 5);
      start = 1; cycle("t1_start");
      for (int i = 0; i < 6; i++) begin
         tick = 1; cycle("t1_tick");
         if (i == 4) begin
            check("t1_5ticks_min", min, 1);
            check("t1_5ticks_sec", sec, 0);
         end
      end
      check("t1_6ticks_sec", sec, 59);
      check("t1_6ticks_min", min, 0);
      check("t1_state_run", state, 2'b01);

      // 1:00:00 needs both borrows on one edge.
      pause = 1; cycle("t2_pause");
      do_load(1, 0, 0);
      start = 1; cycle("t2_start");
      tick = 1; cycle("t2_tick");
      check("t2_hr", hr, 0);
      check("t2_min", min, 59);
      check("t2_sec", sec, 59);

      // Expiry and clear.
      pause = 1; cycle("t3_pause");
      do_load(0, 0, 2);
      start = 1; cycle("t3_start");
      tick = 1; cycle("t3_tick1");
      tick = 1; cycle("t3_tick2");
      check("t3_state_exp", state, 2'b11);
      check("t3_pulse_hi", expired_pulse, 1);
      check("t3_expired_hi", expired, 1);
      for (int i = 0; i < 3; i++) begin
         tick = 1; cycle("t3_post_tick");
         check("t3_pulse_lo", expired_pulse, 0);
         check("t3_expired_held", expired, 1);
         check("t3_sec_held", sec, 0);
      end
      clear = 1; cycle("t3_clear");
      check("t3_clear_state", state, 2'b00);
      check("t3_clear_exp", expired, 0);

      // Pause vs tick, start vs tick.
      do_load(0, 0, 10);
      start = 1; cycle("t4_start");
      pause = 1; tick = 1; cycle("t4_pause_tick");
      check("t4_sec_kept", sec, 10);
      check("t4_state_paused", state, 2'b10);
      start = 1; tick = 1; cycle("t4_start_tick");
      check("t4_resume_state", state, 2'b01);
      check("t4_resume_sec", sec, 10);
      tick = 1; cycle("t4_tick");
      check("t4_sec9", sec, 9);

      // Load is ignored while running.
      pause = 1; cycle("t5_pause");
      do_load(0, 5, 0);
      start = 1; cycle("t5_start");
      tick = 1; cycle("t5_tick");
      load = 1; load_sec = 30; cycle("t5_load_ignored");
      check("t5_ign_min", min, 4);
      check("t5_ign_sec", sec, 59);
      check("t5_ign_state", state, 2'b01);
      load = 1; load_sec = 30; tick = 1; cycle("t5_load_tick");
      check("t5_cont_sec", sec, 58);
      pause = 1; cycle("t5_pause2");
      do_load(0, 0, 30);
      check("t5_loaded_sec", sec, 30);
      check("t5_loaded_state", state, 2'b00);

      // Clamping, start at zero, reset mid-run.
      do_load(120, 61, 75);
      check("t6_clamp_hr", hr, 99);
      check("t6_clamp_min", min, 59);
      check("t6_clamp_sec", sec, 59);
      async_reset("t6_reset_idle");
      start = 1; cycle("t6_start_zero");
      check("t6_zero_state", state, 2'b00);
      do_load(0, 0, 20);
      start = 1; cycle("t6_start");
      tick = 1; cycle("t6_tick");
      async_reset("t6_reset_run");

      // Random control traffic against the model.
      for (int i = 0; i < 600; i++) begin
         load  = ($urandom_range(0, 19) == 0);
         start = ($urandom_range(0, 7) == 0);
         pause = ($urandom_range(0, 14) == 0);
         clear = ($urandom_range(0, 9) == 0);
         tick  = ($urandom_range(0, 3) != 0);
         load_hr  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'd0;
         load_min = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 1));
         load_sec = 8'($urandom_range(0, 90));
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting hh:mm:ss timer for the digital clock design.
- It is the decrementing counterpart of the up-count seconds/minutes/hours chain: it decrements on a 1 Hz enable pulse and propagates borrows from seconds to minutes to hours.
- A small state machine controls load, start, pause and expiry, and raises an alarm output when the count reaches 00:00:00.
- It sits beside the time-of-day counters and shares their tick source and display path.

Parameters:
SEC_MAX, 60, modulus of the seconds field (legal values 0..SEC_MAX-1)
MIN_MAX, 60, modulus of the minutes field
HR_MAX, 100, modulus of the hours field (legal values 0..99)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle enable pulse, nominally 1 Hz
load  input  1  load request, sampled each clk
load_hr  input  8  binary hours value to load
load_min  input  8  binary minutes value to load
load_sec  input  8  binary seconds value to load
start  input  1  start/resume request
pause  input  1  pause request
clear  input  1  acknowledge expiry and return to IDLE
hr  output  8  current hours, binary
min  output  8  current minutes, binary
sec  output  8  current seconds, binary
state  output  2  IDLE=00, RUN=01, PAUSED=10, EXPIRED=11
expired  output  1  level; high while in EXPIRED
expired_pulse  output  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset and clocking
  - Reset (async, active-high) sets hr=min=sec=0, state=IDLE, expired=0, expired_pulse=0.
  - All outputs are registered. Every update occurs on the clk edge that samples the causing input; there is no added latency.
- Input priority within a cycle: load > clear > pause > start > tick.
- load
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUN.
  - Each field is clamped to its modulus-1 (load_sec=75 gives sec=59; load_hr=120 gives hr=99).
  - Next state is IDLE; expired drops to 0.
- start
  - In IDLE or PAUSED with a nonzero count: go to RUN.
  - With count 00:00:00: stay in the current state; there is no expiry.
  - Ignored in RUN and EXPIRED.
- pause
  - In RUN: go to PAUSED. A tick in the same cycle is discarded; no decrement.
  - Ignored in all other states.
- clear
  - In EXPIRED: go to IDLE; expired drops to 0; count stays 00:00:00.
  - Ignored in all other states.
- tick in RUN (decrement with borrow chain)
  - If sec>0: sec-1.
  - Else: sec=SEC_MAX-1 and borrow to minutes.
  - Minute borrow: if min>0, min-1. Else min=MIN_MAX-1 and borrow to hours (hr-1).
  - A borrow never occurs from 00:00:00, because RUN always exits at zero.
- Expiry
  - The tick that takes the count to 00:00:00 moves state to EXPIRED on the same edge.
  - On that edge expired_pulse=1 for exactly one cycle and expired=1.
- tick outside RUN is ignored; the count holds.
- tick held high on consecutive cycles decrements once per cycle (no edge detection inside the block).
- Reset asserted mid-RUN returns to reset values immediately, regardless of clk.
- expired_pulse is 0 in every cycle other than the EXPIRED entry edge.

Test Plan:
- Reset, load 0:01:05, start, 6 ticks -> after 5 ticks 00:01:00; after 6th 00:00:59; state=01.
- Load 1:00:00, start, 1 tick -> 00:59:59, with both borrows on one edge.
- Load 0:00:02, start, 2 ticks -> 00:00:00, state=11, expired_pulse high exactly one cycle, expired stays 1. Then 3 more ticks -> count unchanged. Then clear -> state=00, expired=0.
- RUN at 00:00:10, assert pause and tick in the same cycle -> sec stays 10, state=10. Start + tick next cycle -> RUN, with the tick discarded (start outranks it). Next tick -> 00:00:09.
- RUN at 00:05:00, pulse load with 0:00:30 -> ignored, count continues. Pause, then load -> 00:00:30, state=00.
- Load hr=120, min=61, sec=75 -> 99:59:59. Start with count 0 after a fresh reset -> state stays 00. Assert reset mid-RUN between clk edges -> outputs 0 immediately.
